// File: rtl/mux_nto1_skid.sv
// N_IN:1 WIDTH-bit selector feeding a 2-entry skid stage; an accepted beat is on out_data next cycle, 1 beat/cycle sustained.
// Backpressure: out_ready low holds main stable, the next beat lands in skid, then in_ready (a flop) drops until skid drains.
module mux_nto1_skid #(
    parameter int WIDTH = 16,
    parameter int N_IN  = 6,
    parameter int SEL_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err,
    input  logic                  err_clr
);

    if (N_IN < 2 || (1 << SEL_W) < N_IN) begin : g_bad_params
        $error("mux_nto1_skid: N_IN must be >= 2 and fit in SEL_W bits");
    end

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] data;
    } beat_t;

    state_t     state, next_state;
    beat_t      main_q, skid_q;
    logic [WIDTH-1:0] pick_dat;
    logic       accept, emit, sel_oor;
    logic       load_main_in, load_main_skid, load_skid;
    int         eff_idx;

    assign accept    = in_valid & in_ready;
    assign out_valid = (state != EMPTY);
    assign emit      = out_valid & out_ready;
    assign out_data  = main_q.data;
    assign out_sel   = main_q.sel;

    // Out-of-range selects fall back to the last input, matching the legacy mux.
    assign sel_oor = (int'(sel) >= N_IN);
    assign eff_idx = sel_oor ? (N_IN - 1) : int'(sel);

    always_comb begin
        pick_dat = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (k == eff_idx) pick_dat = in_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    next_state   = ONE;
                end
            end
            ONE: begin
                if (accept && emit) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    load_skid  = 1'b1;
                    next_state = FULL;
                end else if (emit) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (emit) begin
                    load_main_skid = 1'b1;
                    next_state     = ONE;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            main_q   <= '0;
            skid_q   <= '0;
            sel_err  <= 1'b0;
        end else begin
            state    <= next_state;
            // Registered ready: no combinational path from out_ready.
            in_ready <= (next_state != FULL);
            if (load_main_in) begin
                main_q.data <= pick_dat;
                main_q.sel  <= sel;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q.data <= pick_dat;
                skid_q.sel  <= sel;
            end
            if (accept && sel_oor) begin
                sel_err <= 1'b1;
            end else if (err_clr) begin
                sel_err <= 1'b0;
            end
        end
    end

endmodule
